// File: rtl/key_event_pkg.sv
// key_event_pkg: event type codes and channel FSM state encoding shared by key_event_ctrl
package key_event_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_LONG    = 2'd2;
    localparam logic [1:0] EVT_REPEAT  = 2'd3;

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_PRESS_DB,
        ST_PRESSED,
        ST_LONG,
        ST_RELEASE_DB
    } ch_state_e;

    // A key counts as down from the accepted press until its release is confirmed
    function automatic logic is_down(input ch_state_e s);
        return (s == ST_PRESSED) || (s == ST_LONG) || (s == ST_RELEASE_DB);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel - 2-FF synchroniser, debounce/hold FSM and registered event strobe.
// Auto-repeat while in LONG is built only when KEY_EVT_AUTOREPEAT_EN is defined.
module key_debounce_ch
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       key_i,
    output logic       evt_stb_o,
    output logic [1:0] evt_type_o,
    output logic       state_o
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int HW = $clog2(LONG_CYC + 1);
    localparam logic IDLE = (KEY_ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DEB_M1  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_M1 = HW'(LONG_CYC - 1);

    ch_state_e     state_q;
    logic [1:0]    sync_q;
    logic [DW-1:0] dcnt_q;
    logic [HW-1:0] hcnt_q;
    logic          was_long_q;
    logic          stb_q;
    logic [1:0]    type_q;
    logic          down;
`ifdef KEY_EVT_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC + 1);
    localparam logic [RW-1:0] REP_M1 = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rcnt_q;
`endif

    // Synchronised pin, normalised so 1 means pressed
    assign down = sync_q[1] ^ IDLE;

    // Channel FSM: debounce both edges, time the hold, emit one-cycle event strobes
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q     <= {2{IDLE}};
            state_q    <= ST_RELEASED;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            was_long_q <= 1'b0;
            stb_q      <= 1'b0;
            type_q     <= EVT_PRESS;
`ifdef KEY_EVT_AUTOREPEAT_EN
            rcnt_q     <= '0;
`endif
        end else begin
            sync_q <= {sync_q[0], key_i};
            stb_q  <= 1'b0;
            // Hold time keeps counting through release bounces, saturating at the LONG threshold
            if ((state_q == ST_PRESSED || state_q == ST_RELEASE_DB) && hcnt_q != LONG_M1)
                hcnt_q <= hcnt_q + HW'(1);
            case (state_q)
                ST_RELEASED: begin
                    if (down) begin
                        state_q <= ST_PRESS_DB;
                        dcnt_q  <= DW'(1);
                    end
                end
                ST_PRESS_DB: begin
                    if (!down) begin
                        state_q <= ST_RELEASED;
                    end else if (dcnt_q >= DEB_M1) begin
                        state_q <= ST_PRESSED;
                        hcnt_q  <= '0;
                        stb_q   <= 1'b1;
                        type_q  <= EVT_PRESS;
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!down) begin
                        state_q    <= ST_RELEASE_DB;
                        dcnt_q     <= DW'(1);
                        was_long_q <= 1'b0;
                    end else if (hcnt_q == LONG_M1) begin
                        state_q <= ST_LONG;
                        stb_q   <= 1'b1;
                        type_q  <= EVT_LONG;
`ifdef KEY_EVT_AUTOREPEAT_EN
                        rcnt_q  <= '0;
`endif
                    end
                end
                ST_LONG: begin
                    if (!down) begin
                        state_q    <= ST_RELEASE_DB;
                        dcnt_q     <= DW'(1);
                        was_long_q <= 1'b1;
                    end
`ifdef KEY_EVT_AUTOREPEAT_EN
                    else if (rcnt_q == REP_M1) begin
                        rcnt_q <= '0;
                        stb_q  <= 1'b1;
                        type_q <= EVT_REPEAT;
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
`endif
                end
                ST_RELEASE_DB: begin
                    if (down) begin
                        state_q <= was_long_q ? ST_LONG : ST_PRESSED;
                    end else if (dcnt_q >= DEB_M1) begin
                        state_q <= ST_RELEASED;
                        stb_q   <= 1'b1;
                        type_q  <= EVT_RELEASE;
                    end else begin
                        dcnt_q <= dcnt_q + DW'(1);
                    end
                end
                default: state_q <= ST_RELEASED;
            endcase
        end
    end

    assign evt_stb_o  = stb_q;
    assign evt_type_o = type_q;
    assign state_o    = is_down(state_q);

endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounced multi-key event source merged onto one valid/ready stream (round-robin).
// Define KEY_EVT_AUTOREPEAT_EN to enable REPEAT events while a key is held past LONG.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int KEYS           = 4,
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int LONG_CYC       = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int KEY_ACTIVE_LOW = 1,
    localparam int IW = (KEYS > 1) ? $clog2(KEYS) : 1
) (
    input  logic            clk100_i,
    input  logic            arstn_i,
    input  logic [KEYS-1:0] key_i,
    input  logic            event_ready_i,
    output logic            event_valid_o,
    output logic [IW-1:0]   event_key_o,
    output logic [1:0]      event_type_o,
    output logic [KEYS-1:0] key_state_o,
    output logic [KEYS-1:0] ovf_o
);

    logic [KEYS-1:0]      evt_stb;
    logic [KEYS-1:0][1:0] evt_type;
    logic [KEYS-1:0]      pend_q, pend_d, ovf_q, ovf_d;
    logic [KEYS-1:0][1:0] ptype_q, ptype_d;
    logic                 valid_q, valid_d;
    logic [IW-1:0]        key_q, key_d, ptr_q, ptr_d, gnt;
    logic [1:0]           type_q, type_d;
    logic                 gnt_vld, load;

    genvar g;
    generate
        for (g = 0; g < KEYS; g++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYC  (DEBOUNCE_CYC),
                .LONG_CYC      (LONG_CYC),
                .REPEAT_CYC    (REPEAT_CYC),
                .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
            ) u_ch (
                .clk_i     (clk100_i),
                .arstn_i   (arstn_i),
                .key_i     (key_i[g]),
                .evt_stb_o (evt_stb[g]),
                .evt_type_o(evt_type[g]),
                .state_o   (key_state_o[g])
            );
        end
    endgenerate

    // Round-robin pick: scan offsets high to low so the smallest offset from ptr wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            logic [IW-1:0] c;
            c = IW'((int'(ptr_q) + i) % KEYS);
            if (pend_q[c]) begin
                gnt_vld = 1'b1;
                gnt     = c;
            end
        end
    end

    assign load = gnt_vld && (!valid_q || event_ready_i);

    // Output register refill and pending bookkeeping; a fresh strobe on a slot being issued is not an overflow
    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        type_d  = type_q;
        ptr_d   = ptr_q;
        pend_d  = pend_q;
        ptype_d = ptype_q;
        ovf_d   = ovf_q;
        if (load) begin
            valid_d     = 1'b1;
            key_d       = gnt;
            type_d      = ptype_q[gnt];
            pend_d[gnt] = 1'b0;
            ptr_d       = (gnt == IW'(KEYS - 1)) ? '0 : gnt + IW'(1);
        end else if (event_ready_i) begin
            valid_d = 1'b0;
        end
        for (int k = 0; k < KEYS; k++) begin
            if (evt_stb[k]) begin
                ovf_d[k]   = ovf_q[k] | pend_d[k];
                pend_d[k]  = 1'b1;
                ptype_d[k] = evt_type[k];
            end
        end
    end

    // State registers
    always_ff @(posedge clk100_i or negedge arstn_i) begin
        if (!arstn_i) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            type_q  <= '0;
            ptr_q   <= '0;
            pend_q  <= '0;
            ptype_q <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= valid_d;
            key_q   <= key_d;
            type_q  <= type_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            ptype_q <= ptype_d;
            ovf_q   <= ovf_d;
        end
    end

    assign event_valid_o = valid_q;
    assign event_key_o   = key_q;
    assign event_type_o  = type_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed self-checking bench for key_event_ctrl (DEBOUNCE 4, LONG 20, REPEAT 8, active-high keys).
module tb_key_event_ctrl;

    localparam logic [1:0] P = 2'd0;
    localparam logic [1:0] R = 2'd1;
    localparam logic [1:0] L = 2'd2;
    localparam logic [1:0] T = 2'd3;

    logic       clk = 1'b0;
    logic       arstn;
    logic [3:0] key;
    logic       ready;
    logic       event_valid_o;
    logic [1:0] event_key_o;
    logic [1:0] event_type_o;
    logic [3:0] key_state_o;
    logic [3:0] ovf_o;
    int         n_assert = 0;
    int         n_fail = 0;

    key_event_ctrl #(
        .KEYS          (4),
        .DEBOUNCE_CYC  (4),
        .LONG_CYC      (20),
        .REPEAT_CYC    (8),
        .KEY_ACTIVE_LOW(0)
    ) dut (
        .clk100_i     (clk),
        .arstn_i      (arstn),
        .key_i        (key),
        .event_ready_i(ready),
        .event_valid_o(event_valid_o),
        .event_key_o  (event_key_o),
        .event_type_o (event_type_o),
        .key_state_o  (key_state_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for valid, check latency and payload, optionally take the handshake edge
    task automatic expect_evt(input string tag, input int max, input int exp_n,
                              input logic [1:0] k, input logic [1:0] t, input bit consume);
        int n = 0;
        while (event_valid_o !== 1'b1 && n < max) begin
            step();
            n++;
        end
        check({tag, " wait"}, n, exp_n);
        check({tag, " key"}, event_key_o, k);
        check({tag, " type"}, event_type_o, t);
        if (consume) step();
    endtask

    task automatic quiet(input string tag, input int cyc);
        int seen = 0;
        repeat (cyc) begin
            step();
            if (event_valid_o !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arstn = 1'b0;
        key   = 4'h0;
        ready = 1'b1;
        repeat (3) step();
        check("rst valid", event_valid_o, 0);
        check("rst key", event_key_o, 0);
        check("rst type", event_type_o, 0);
        check("rst state", key_state_o, 0);
        check("rst ovf", ovf_o, 0);
        arstn = 1'b1;
        repeat (2) step();

        // All four pressed together from ptr 0
        key = 4'hF;
        expect_evt("all p0", 20, 8, 0, P, 1);
        expect_evt("all p1", 20, 0, 1, P, 1);
        expect_evt("all p2", 20, 0, 2, P, 1);
        expect_evt("all p3", 20, 0, 3, P, 1);
        check("all state", key_state_o, 4'hF);
        key = 4'h0;
        expect_evt("all r0", 20, 8, 0, R, 1);
        expect_evt("all r1", 20, 0, 1, R, 1);
        expect_evt("all r2", 20, 0, 2, R, 1);
        expect_evt("all r3", 20, 0, 3, R, 1);
        // Key 1 alone moves ptr to 2
        key = 4'b0010;
        expect_evt("k1 p", 20, 8, 1, P, 1);
        key = 4'h0;
        expect_evt("k1 r", 20, 8, 1, R, 1);
        key = 4'hF;
        expect_evt("rr p2", 20, 8, 2, P, 1);
        expect_evt("rr p3", 20, 0, 3, P, 1);
        expect_evt("rr p0", 20, 0, 0, P, 1);
        expect_evt("rr p1", 20, 0, 1, P, 1);
        key = 4'h0;
        expect_evt("rr r2", 20, 8, 2, R, 1);
        expect_evt("rr r3", 20, 0, 3, R, 1);
        expect_evt("rr r0", 20, 0, 0, R, 1);
        expect_evt("rr r1", 20, 0, 1, R, 1);

        // Clean press on key 0, held 10 cycles
        key = 4'b0001;
        expect_evt("t1 press", 20, 8, 0, P, 1);
        check("t1 state", key_state_o, 4'b0001);
        check("t1 single", event_valid_o, 0);
        step();
        key = 4'b0000;
        expect_evt("t1 release", 20, 8, 0, R, 1);
        check("t1 state off", key_state_o, 4'b0000);

        // Bouncing key 1
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                key[1] = ((i / 2) % 2 == 0);
                step();
                if (event_valid_o !== 1'b0) seen++;
            end
            check("t2 bounce quiet", seen, 0);
        end
        key[1] = 1'b1;
        expect_evt("t2 press", 20, 8, 1, P, 1);
        key[1] = 1'b0;
        expect_evt("t2 release", 20, 8, 1, R, 1);

        // Long hold on key 2
        key = 4'b0100;
        expect_evt("t3 press", 20, 8, 2, P, 1);
        expect_evt("t3 long", 30, 19, 2, L, 1);
        check("t3 state", key_state_o, 4'b0100);
`ifdef KEY_EVT_AUTOREPEAT_EN
        expect_evt("t3 rep1", 20, 7, 2, T, 1);
        repeat (3) step();
        key = 4'b0000;
        expect_evt("t3 rep2", 20, 4, 2, T, 1);
        expect_evt("t3 release", 20, 3, 2, R, 1);
`else
        quiet("t3 no repeat", 11);
        key = 4'b0000;
        expect_evt("t3 release", 20, 8, 2, R, 1);
`endif

        // Blocked consumer on key 3
        ready = 1'b0;
        key = 4'b1000;
        expect_evt("t5 press", 20, 8, 3, P, 0);
        key = 4'b0000;
        repeat (12) step();
        check("t5 hold valid", event_valid_o, 1);
        check("t5 hold key", event_key_o, 3);
        check("t5 hold type", event_type_o, P);
        check("t5 no ovf", ovf_o, 0);
        key = 4'b1000;
        repeat (10) step();
        key = 4'b0000;
        repeat (10) step();
        check("t5 ovf", ovf_o, 4'b1000);
        check("t5 still valid", event_valid_o, 1);
        check("t5 still key", event_key_o, 3);
        check("t5 still type", event_type_o, P);
        ready = 1'b1;
        step();
        check("t5 b2b valid", event_valid_o, 1);
        check("t5 b2b key", event_key_o, 3);
        check("t5 b2b type", event_type_o, R);
        step();
        check("t5 drained", event_valid_o, 0);
        check("t5 ovf sticky", ovf_o, 4'b1000);

        // Reset during LONG hold on key 2
        key = 4'b0100;
        expect_evt("t6 press", 20, 8, 2, P, 1);
        ready = 1'b0;
        expect_evt("t6 long", 30, 19, 2, L, 0);
        repeat (3) step();
        arstn = 1'b0;
        #1;
        check("t6 rst valid", event_valid_o, 0);
        check("t6 rst key", event_key_o, 0);
        check("t6 rst type", event_type_o, 0);
        check("t6 rst state", key_state_o, 0);
        check("t6 rst ovf", ovf_o, 0);
        repeat (2) step();
        ready = 1'b1;
        arstn = 1'b1;
        expect_evt("t6 fresh press", 20, 8, 2, P, 1);
        check("t6 state", key_state_o, 4'b0100);
        key = 4'b0000;
        expect_evt("t6 release", 20, 8, 2, R, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
